// File: rtl/cim_accum_packer.sv
// -----------------------------------------------------------------------------
// cim_accum_packer
//
// Downstream stage of the CIM bit-serial accumulator. Each signed ACC_W-bit
// accumulated result is requantized to a signed byte in three steps: a
// rounding arithmetic right shift, an optional ReLU and saturation to
// [-128,127]. Four bytes are packed into a 32-bit word, with lane 0 in the LSB
// and lane 0 being the first arrival. Words are buffered in a
// first-word-fall-through FIFO that the consumer drains with valid/ready.
//
// Optional feature (macro CIM_SAT_CNT_EN):
//   When defined, adds sat_count[7:0]. It counts results that were clipped to
//   -128 or 127 from outside that range, and it saturates at 255.
//
// Ports:
//   clk             clock; all logic on the rising edge
//   RST             synchronous active-high reset
//   accum_in        signed accumulated result
//   accum_in_valid  one-cycle qualifier for accum_in
//   shift           right-shift amount 0..15, sampled with accum_in_valid
//   relu_en         clamp negatives to 0, sampled with accum_in_valid
//   flush           push the partially filled word
//   word_out        FIFO head word (0 while empty)
//   word_valid      FIFO not empty
//   word_ready      consumer accepts word_out
//   fifo_count      number of words held
//   overflow        sticky: a word was dropped because the FIFO was full
//   sat_count       saturation event counter (CIM_SAT_CNT_EN only)
// -----------------------------------------------------------------------------
module cim_accum_packer #(
  parameter int ACC_W      = 18,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic signed [ACC_W-1:0] accum_in,
  input  logic                    accum_in_valid,
  input  logic [3:0]              shift,
  input  logic                    relu_en,
  input  logic                    flush,
  output logic [31:0]             word_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    overflow
`ifdef CIM_SAT_CNT_EN
  ,
  output logic [7:0]              sat_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic signed [ACC_W:0] BYTE_MAX = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] BYTE_MIN = -(ACC_W+1)'(128);

  // ---------------------------------------------------------------------------
  // Stage 1: round, shift, ReLU, saturate
  // ---------------------------------------------------------------------------
  logic signed [ACC_W:0] s1_wide;
  logic signed [ACC_W:0] s1_rnd;
  logic signed [ACC_W:0] s1_sum;
  logic signed [ACC_W:0] s1_shr;
  logic [7:0]            s1_byte_d;
  logic                  s1_clip_d;

  logic [7:0]            s1_byte;
  logic                  s1_valid;

  // NOTE: combinational blocks assign every output a default first and use
  // blocking assignments. This way, no path can leave a value held and infer a latch.
  always_comb begin
    s1_rnd    = '0;
    s1_clip_d = 1'b0;
    // The extra sign bit absorbs the rounding carry: the largest positive input
    // plus 2^14 still fits in ACC_W+1 bits.
    s1_wide   = {accum_in[ACC_W-1], accum_in};
    if (shift != 4'd0) begin
      s1_rnd = (ACC_W+1)'(1) << (shift - 4'd1);
    end
    s1_sum = s1_wide + s1_rnd;
    s1_shr = s1_sum >>> shift;

    // A ReLU clamp takes precedence over saturation. A clamp is not counted as
    // a saturation event.
    if (relu_en && (s1_shr < 0)) begin
      s1_byte_d = 8'h00;
    end else if (s1_shr > BYTE_MAX) begin
      s1_byte_d = 8'h7f;
      s1_clip_d = 1'b1;
    end else if (s1_shr < BYTE_MIN) begin
      s1_byte_d = 8'h80;
      s1_clip_d = 1'b1;
    end else begin
      s1_byte_d = s1_shr[7:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. This way,
  // every register samples the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_byte  <= 8'h00;
    end else begin
      s1_valid <= accum_in_valid;
      if (accum_in_valid) begin
        s1_byte <= s1_byte_d;
      end
    end
  end

`ifdef CIM_SAT_CNT_EN
  logic s1_clip;

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_clip   <= 1'b0;
      sat_count <= 8'd0;
    end else begin
      if (accum_in_valid) begin
        s1_clip <= s1_clip_d;
      end
      if (s1_valid && s1_clip && (sat_count != 8'hff)) begin
        sat_count <= sat_count + 8'd1;
      end
    end
  end
`else
  logic unused_sat_clip;
  assign unused_sat_clip = s1_clip_d;
`endif

  // ---------------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------------
  logic [1:0]  lane, lane_d;
  logic [23:0] pack, pack_d;
  logic [31:0] merged;
  logic [31:0] push_word;
  logic        push;

  always_comb begin
    lane_d    = lane;
    pack_d    = pack;
    push      = 1'b0;
    push_word = '0;
    // Unused upper lanes read as 0 when a word is flushed early.
    merged    = {8'h00, pack};
    merged[{lane, 3'b000} +: 8] = s1_byte;

    if (s1_valid) begin
      // A flush that coincides with an arriving byte includes that byte. It
      // then pushes once, even when the byte completes the word.
      if ((lane == 2'd3) || flush) begin
        push      = 1'b1;
        push_word = merged;
        pack_d    = '0;
        lane_d    = 2'd0;
      end else begin
        pack_d = merged[23:0];
        lane_d = lane + 2'd1;
      end
    end else if (flush && (lane != 2'd0)) begin
      push      = 1'b1;
      push_word = {8'h00, pack};
      pack_d    = '0;
      lane_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      lane <= 2'd0;
      pack <= '0;
    end else begin
      lane <= lane_d;
      pack <= pack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, wr_en;

  assign word_valid = (fifo_count != '0);
  assign full       = (fifo_count == CNT_W'(FIFO_DEPTH));
  // Gating on word_valid means a pop on an empty FIFO cannot happen, even if a
  // push is stored in the same cycle.
  assign pop        = word_valid && word_ready;
  // When the FIFO is full, a simultaneous pop makes room for the push.
  assign wr_en      = push && (!full || pop);
  // Present 0 while empty, so the stale storage never appears on the bus.
  assign word_out   = word_valid ? mem[rd_ptr] : 32'h0;

  // NOTE: the storage array has no reset. Its contents are only observed
  // through word_valid, and the pointers and count carry all reset state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // The pointers are a power-of-two width, so they wrap naturally.
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
